// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_types_pkg
// Brief    : Shared ALU opcode type, ALU BIST op order, polynomial and corners.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'd0,
      ALU_SRL  = 4'd1,
      ALU_ADD  = 4'd2,
      ALU_SUB  = 4'd3,
      ALU_AND  = 4'd4,
      ALU_OR   = 4'd5,
      ALU_XOR  = 4'd6,
      ALU_NOR  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } aluop_t;

   localparam int C_NUM_OPS = 10;

   localparam aluop_t C_OP_TABLE [C_NUM_OPS] = '{
      ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
      ALU_OR,  ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
   };

   // Shared by the operand LFSRs and the signature MISR
   localparam logic [31:0] C_POLY = 32'h8020_0003;

   localparam logic [31:0] C_CORNER_A [4] = '{32'h0000_0000, 32'hFFFF_FFFF,
                                              32'h7FFF_FFFF, 32'h8000_0000};
   localparam logic [31:0] C_CORNER_B [4] = '{32'h0000_0000, 32'h0000_0001,
                                              32'h0000_0001, 32'hFFFF_FFFF};

   function automatic logic [31:0] poly_step(input logic [31:0] v);
      return {v[30:0], 1'b0} ^ (v[31] ? C_POLY : 32'h0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_if
// Brief    : ALU operand/result bundle with tester and ALU views.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_if;
   import cpu_types_pkg::*;

   logic [31:0] A;
   logic [31:0] B;
   aluop_t      aluop;
   logic [31:0] ALUout;
   logic        negative;
   logic        overflow;
   logic        zero;

   modport alu_tb (output A, B, aluop, input ALUout, negative, overflow, zero);
   modport alu    (input A, B, aluop, output ALUout, negative, overflow, zero);
endinterface
`default_nettype wire

// File: rtl/lfsr32.sv
`default_nettype none
// ============================================================================
// Module   : lfsr32
// Brief    : 32-bit Galois LFSR with seed reload and single-step advance.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr32
   import cpu_types_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        advance,
   output logic [31:0] value
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         value <= SEED;
      else if (load)
         value <= SEED;
      else if (advance)
         value <= poly_step(value);
   end

endmodule
`default_nettype wire

// File: rtl/alu_bist.sv
`default_nettype none
// ============================================================================
// Module   : alu_bist
// Brief    : ALU self-test: corner + LFSR operands for every op, MISR signature.
// Revision : 1.0 - initial release
// ============================================================================
module alu_bist
   import cpu_types_pkg::*;
#(
   parameter int          N_VECTORS = 64,
   parameter logic [31:0] SEED_A    = 32'h1,
   parameter logic [31:0] SEED_B    = 32'hACE1_2468
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] golden_sig,
   alu_if.alu_tb       aluif,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [31:0] signature
);

   localparam int             C_VW       = $clog2(N_VECTORS);
   localparam logic [C_VW-1:0] C_LAST_VEC = C_VW'(N_VECTORS - 1);
   localparam logic [3:0]     C_LAST_OP  = 4'(C_NUM_OPS - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      APPLY   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t          r_state;
   logic [3:0]      r_op;
   logic [C_VW-1:0] r_vec;
   logic [31:0]     r_a;
   logic [31:0]     r_b;
   aluop_t          r_aluop;
   logic [31:0]     r_golden;

   logic [31:0]     w_lfsr_a;
   logic [31:0]     w_lfsr_b;
   logic            w_accept;
   logic            w_last_vec;
   logic            w_last_op;
   logic            w_is_corner;
   logic            w_next_corner;
   logic [C_VW-1:0] w_next_vec;
   logic [3:0]      w_next_op;
   logic            w_lfsr_load;
   logic            w_lfsr_adv;
   logic [31:0]     w_data;

   assign w_accept      = start && (r_state == IDLE || r_state == DONE);
   assign w_last_vec    = (r_vec == C_LAST_VEC);
   assign w_last_op     = (r_op == C_LAST_OP);
   assign w_is_corner   = (32'(r_vec) < 32'd4);
   assign w_next_vec    = w_last_vec ? '0 : r_vec + 1'b1;
   assign w_next_op     = w_last_vec ? r_op + 4'd1 : r_op;
   assign w_next_corner = (32'(w_next_vec) < 32'd4);
   assign w_data        = aluif.ALUout ^ {29'b0, aluif.negative, aluif.overflow, aluif.zero};

   // Reload on every op change so each op sees the same random operand stream
   assign w_lfsr_load = w_accept || (r_state == CAPTURE && w_last_vec && !w_last_op);
   assign w_lfsr_adv  = (r_state == CAPTURE) && !w_is_corner;

   lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
      .clk     (clk),
      .rst     (rst),
      .load    (w_lfsr_load),
      .advance (w_lfsr_adv),
      .value   (w_lfsr_a)
   );

   lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
      .clk     (clk),
      .rst     (rst),
      .load    (w_lfsr_load),
      .advance (w_lfsr_adv),
      .value   (w_lfsr_b)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_op      <= '0;
         r_vec     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_aluop   <= ALU_SLL;
         r_golden  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         signature <= '0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_state   <= APPLY;
                  r_op      <= '0;
                  r_vec     <= '0;
                  r_a       <= C_CORNER_A[0];
                  r_b       <= C_CORNER_B[0];
                  r_aluop   <= C_OP_TABLE[0];
                  r_golden  <= golden_sig;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  signature <= '0;
               end
            end
            APPLY: r_state <= CAPTURE;
            CAPTURE: begin
               signature <= poly_step(signature) ^ w_data;
               if (w_last_vec && w_last_op) begin
                  r_state <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  r_state <= APPLY;
                  r_vec   <= w_next_vec;
                  r_op    <= w_next_op;
                  r_aluop <= C_OP_TABLE[w_next_op];
                  if (w_next_corner) begin
                     r_a <= C_CORNER_A[w_next_vec[1:0]];
                     r_b <= C_CORNER_B[w_next_vec[1:0]];
                  end else if (w_is_corner) begin
                     r_a <= w_lfsr_a;
                     r_b <= w_lfsr_b;
                  end else begin
                     // LFSRs step on this same edge; present the value they step to
                     r_a <= poly_step(w_lfsr_a);
                     r_b <= poly_step(w_lfsr_b);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign aluif.A     = r_a;
   assign aluif.B     = r_b;
   assign aluif.aluop = r_aluop;
   assign pass        = done && (signature == r_golden);

endmodule
`default_nettype wire

// File: tb/tb_alu_bist.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_bist
// Brief    : Directed bench for alu_bist with behavioural ALU and signature model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_bist;
   import cpu_types_pkg::*;

   localparam logic [31:0] SA = 32'h1;
   localparam logic [31:0] SB = 32'hACE1_2468;
   localparam aluop_t TB_OPS [10] = '{ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
                                      ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] golden4 = '0;
   logic [31:0] golden8 = '0;
   logic        fault_en = 1'b0;
   logic [31:0] fa = '0;
   logic [31:0] fb = '0;
   logic        busy4, done4, pass4, busy8, done8, pass8;
   logic [31:0] sig4, sig8;
   logic [34:0] r4, r8;
   logic        fault8;
   int          checks = 0;
   int          failures = 0;

   alu_if aluif4 ();
   alu_if aluif8 ();

   always #5 clk = ~clk;

   alu_bist #(.N_VECTORS(4), .SEED_A(SA), .SEED_B(SB)) u_dut4 (
      .clk(clk), .rst(rst), .start(start), .golden_sig(golden4), .aluif(aluif4),
      .busy(busy4), .done(done4), .pass(pass4), .signature(sig4));

   alu_bist #(.N_VECTORS(8), .SEED_A(SA), .SEED_B(SB)) u_dut8 (
      .clk(clk), .rst(rst), .start(start), .golden_sig(golden8), .aluif(aluif8),
      .busy(busy8), .done(done8), .pass(pass8), .signature(sig8));

   // Returns {result, negative, overflow, zero}
   function automatic logic [34:0] alu_eval(input aluop_t op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] r;
      logic        ovf;
      r   = '0;
      ovf = 1'b0;
      case (op)
         ALU_SLL:  r = a << b[4:0];
         ALU_SRL:  r = a >> b[4:0];
         ALU_ADD:  begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
         ALU_SUB:  begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_NOR:  r = ~(a | b);
         ALU_SLT:  r = {31'b0, $signed(a) < $signed(b)};
         ALU_SLTU: r = {31'b0, a < b};
         default:  r = '0;
      endcase
      return {r, r[31], ovf, (r == 32'h0)};
   endfunction

   assign r4 = alu_eval(aluif4.aluop, aluif4.A, aluif4.B);
   assign aluif4.ALUout   = r4[34:3];
   assign aluif4.negative = r4[2];
   assign aluif4.overflow = r4[1];
   assign aluif4.zero     = r4[0];

   assign r8 = alu_eval(aluif8.aluop, aluif8.A, aluif8.B);
   assign fault8 = fault_en && (aluif8.aluop == ALU_SUB) && (aluif8.A == fa) && (aluif8.B == fb);
   assign aluif8.ALUout   = r8[34:3] ^ {31'b0, fault8};
   assign aluif8.negative = r8[2];
   assign aluif8.overflow = r8[1];
   assign aluif8.zero     = r8[0];

   function automatic logic [31:0] gstep(input logic [31:0] v);
      logic [31:0] s;
      s = v << 1;
      if (v[31]) s = s ^ 32'h8020_0003;
      return s;
   endfunction

   function automatic logic [63:0] operand(input int v);
      logic [31:0] a, b;
      case (v)
         0: begin a = 32'h0000_0000; b = 32'h0000_0000; end
         1: begin a = 32'hFFFF_FFFF; b = 32'h0000_0001; end
         2: begin a = 32'h7FFF_FFFF; b = 32'h0000_0001; end
         3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         default: begin
            a = SA;
            b = SB;
            for (int i = 4; i < v; i++) begin a = gstep(a); b = gstep(b); end
         end
      endcase
      return {a, b};
   endfunction

   function automatic logic [31:0] model_sig(input int n, input bit fault);
      logic [31:0] s, out, data;
      logic [63:0] ab;
      logic [34:0] r;
      s = '0;
      for (int op = 0; op < 10; op++) begin
         for (int v = 0; v < n; v++) begin
            ab  = operand(v);
            r   = alu_eval(TB_OPS[op], ab[63:32], ab[31:0]);
            out = r[34:3];
            if (fault && TB_OPS[op] == ALU_SUB && v == 7) out[0] = ~out[0];
            data = out ^ {29'b0, r[2:0]};
            s = gstep(s) ^ data;
         end
      end
      return s;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic pulse_start;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic run_to_done(input int limit, output int cyc);
      cyc = 0;
      while (done8 !== 1'b1 && cyc < limit) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("done_within_bound", done8, 1'b1);
   endtask

   typedef struct {
      int          dut;
      int          j;
      logic        busy;
      logic        done;
      logic        ops;
      aluop_t      op;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   localparam int NT = 13;
   vec_t tbl [NT];

   initial begin
      #500000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      logic [31:0] g4, g8, gf;
      logic [63:0] ab;
      logic        early4, early8, bsy, dn;
      logic [31:0] a_act, b_act, op_act;
      int          cyc;

      tbl[0]  = '{4,   0, 1'b1, 1'b0, 1'b1, ALU_SLL,  32'h0000_0000, 32'h0000_0000};
      tbl[1]  = '{4,   8, 1'b1, 1'b0, 1'b1, ALU_SRL,  32'h0000_0000, 32'h0000_0000};
      tbl[2]  = '{4,  18, 1'b1, 1'b0, 1'b1, ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001};
      tbl[3]  = '{4,  19, 1'b1, 1'b0, 1'b1, ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001};
      tbl[4]  = '{4,  20, 1'b1, 1'b0, 1'b1, ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001};
      tbl[5]  = '{4,  23, 1'b1, 1'b0, 1'b1, ALU_ADD,  32'h8000_0000, 32'hFFFF_FFFF};
      tbl[6]  = '{4,  79, 1'b1, 1'b0, 1'b1, ALU_SLTU, 32'h8000_0000, 32'hFFFF_FFFF};
      tbl[7]  = '{4,  80, 1'b0, 1'b1, 1'b0, ALU_SLL,  32'h0,         32'h0};
      tbl[8]  = '{8,   8, 1'b1, 1'b0, 1'b1, ALU_SLL,  32'h0000_0001, 32'hACE1_2468};
      tbl[9]  = '{8,  10, 1'b1, 1'b0, 1'b1, ALU_SLL,  32'h0000_0002, 32'hD9E2_48D3};
      tbl[10] = '{8,  27, 1'b1, 1'b0, 1'b1, ALU_SRL,  32'h0000_0002, 32'hD9E2_48D3};
      tbl[11] = '{8, 159, 1'b1, 1'b0, 1'b1, ALU_SLTU, 32'h0000_0008, 32'h67C9_234A};
      tbl[12] = '{8, 160, 1'b0, 1'b1, 1'b0, ALU_SLL,  32'h0,         32'h0};

      g4 = model_sig(4, 1'b0);
      g8 = model_sig(8, 1'b0);
      gf = model_sig(8, 1'b1);
      ab = operand(7);
      fa = ab[63:32];
      fb = ab[31:0];

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_A", aluif8.A, 32'h0);
      chk("rst_B", aluif8.B, 32'h0);
      chk("rst_aluop", 32'(aluif8.aluop), 32'(ALU_SLL));
      chk("rst_busy", busy8, 1'b0);
      chk("rst_done", done8, 1'b0);
      chk("rst_pass", pass8, 1'b0);
      chk("rst_sig", sig8, 32'h0);
      chk("rst_busy4", busy4, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Full run on both instances, table-driven operand/latency checks
      golden4 = g4;
      golden8 = g8;
      early4  = 1'b0;
      early8  = 1'b0;
      pulse_start();
      for (int j = 0; j <= 160; j++) begin
         for (int i = 0; i < NT; i++) begin
            if (tbl[i].j == j) begin
               bsy    = (tbl[i].dut == 4) ? busy4 : busy8;
               dn     = (tbl[i].dut == 4) ? done4 : done8;
               a_act  = (tbl[i].dut == 4) ? aluif4.A : aluif8.A;
               b_act  = (tbl[i].dut == 4) ? aluif4.B : aluif8.B;
               op_act = (tbl[i].dut == 4) ? 32'(aluif4.aluop) : 32'(aluif8.aluop);
               chk($sformatf("t%0d_busy", i), bsy, tbl[i].busy);
               chk($sformatf("t%0d_done", i), dn, tbl[i].done);
               if (tbl[i].ops) begin
                  chk($sformatf("t%0d_aluop", i), op_act, 32'(tbl[i].op));
                  chk($sformatf("t%0d_A", i), a_act, tbl[i].a);
                  chk($sformatf("t%0d_B", i), b_act, tbl[i].b);
               end
            end
         end
         if (j < 80 && done4 !== 1'b0) early4 = 1'b1;
         if (j < 160 && done8 !== 1'b0) early8 = 1'b1;
         if (j < 160) begin
            @(posedge clk);
            #1;
         end
      end
      chk("early_done4", early4, 1'b0);
      chk("early_done8", early8, 1'b0);
      chk("sig4_golden", sig4, g4);
      chk("pass4", pass4, 1'b1);
      chk("sig8_golden", sig8, g8);
      chk("pass8", pass8, 1'b1);

      // Restart from DONE with a wrong golden value
      golden8 = g8 ^ 32'h1;
      pulse_start();
      chk("restart_done_drop", done8, 1'b0);
      chk("restart_pass_drop", pass8, 1'b0);
      chk("restart_busy", busy8, 1'b1);
      run_to_done(200, cyc);
      chk("badgold_pass", pass8, 1'b0);
      chk("badgold_done", done8, 1'b1);
      chk("badgold_sig", sig8, g8);

      // Single-bit ALU fault on SUB, vector 7
      golden8  = g8;
      fault_en = 1'b1;
      pulse_start();
      run_to_done(200, cyc);
      chk("fault_sig_model", sig8, gf);
      chk("fault_sig_differs", 32'(sig8 == g8), 32'h0);
      chk("fault_pass", pass8, 1'b0);
      fault_en = 1'b0;

      // Asynchronous reset mid-run
      pulse_start();
      repeat (30) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_busy", busy8, 1'b0);
      chk("midrst_done", done8, 1'b0);
      chk("midrst_A", aluif8.A, 32'h0);
      chk("midrst_sig", sig8, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_idle", busy8, 1'b0);

      // Restart with a second start pulse while busy, which must be ignored
      pulse_start();
      repeat (5) @(posedge clk);
      #1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      run_to_done(200, cyc);
      chk("ignored_start_latency", cyc + 6, 160);
      chk("rerun_sig", sig8, g8);
      chk("rerun_pass", pass8, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 The block SHALL have parameter N_VECTORS, default 64, operand pairs applied per ALU operation; legal range 4..4096.
REQ-002 The block SHALL have parameter SEED_A, default 32'h1, reload value of the A-operand LFSR.
REQ-003 The block SHALL have parameter SEED_B, default 32'hACE1_2468, reload value of the B-operand LFSR.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 CLK  input  1  clock; all state changes on its rising edge.
REQ-006 RST  input  1  asynchronous active-high reset.
REQ-007 start  input  1  single-cycle request to run the full self-test.
REQ-008 golden_sig  input  32  expected final signature; sampled on an accepted start.
REQ-009 aluif  alu_if.alu_tb modport  -  drives A, B, aluop; receives ALUout, negative, overflow, zero.
REQ-010 busy  output  1  test in progress.
REQ-011 done  output  1  test complete; held until the next accepted start.
REQ-012 pass  output  1  done and signature equals sampled golden_sig.
REQ-013 signature  output  32  current MISR contents.

Function
REQ-014 FSM states SHALL be IDLE, APPLY, CAPTURE, DONE.
REQ-015 IDLE or DONE with start=1 SHALL go to APPLY; this clears MISR to 0, resets op index and vector index to 0, reloads both LFSRs, and samples golden_sig.
REQ-016 start SHALL be ignored in APPLY and CAPTURE.
REQ-017 APPLY SHALL go to CAPTURE unconditionally; A, B, aluop are registered outputs and stay stable for the full APPLY+CAPTURE pair.
REQ-018 CAPTURE SHALL fold data = ALUout XOR {29'b0, negative, overflow, zero} into the MISR: sig <= {sig[30:0],1'b0} XOR (sig[31] ? 32'h8020_0003 : 0) XOR data.
REQ-019 Operations SHALL form the outer loop, in package-table order: SLL, SRL, ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU (10 ops). Vectors SHALL form the inner loop.
REQ-020 Vector indices 0..3 SHALL be fixed corners (A,B): (0,0), (FFFFFFFF,1), (7FFFFFFF,1), (80000000,FFFFFFFF).
REQ-021 Vector indices 4..N_VECTORS-1 SHALL use the LFSR values; each LFSR advances once per CAPTURE of a random vector. LFSR form: Galois, polynomial 32'h8020_0003.
REQ-022 Both LFSRs SHALL reload their seeds when the op index advances, so every op sees an identical operand sequence.
REQ-023 CAPTURE of the last vector of the last op SHALL go to DONE; otherwise it SHALL go to APPLY with the indices advanced.
REQ-024 Latency: done SHALL rise exactly 2*10*N_VECTORS cycles after the edge that accepts start.
REQ-025 busy SHALL be 1 exactly in APPLY and CAPTURE.
REQ-026 done SHALL be 1 exactly in DONE.
REQ-027 pass SHALL be combinational: done AND (signature == sampled golden).
REQ-028 A start accepted in DONE SHALL drop done and pass on the next edge.

Reset
REQ-029 RST SHALL asynchronously force:
  - state IDLE
  - A=0, B=0, aluop=ALU_SLL
  - busy=0, done=0, pass=0
  - signature=0, sampled golden=0
  - both LFSRs to their seeds
REQ-030 RST asserted mid-run SHALL abort the run with no residual state; the next start SHALL run the full sequence.

Structure
REQ-031 The op-order table, MISR/LFSR polynomial, and corner-vector constants SHALL live in cpu_types_pkg. The FSM state enum SHALL be local.
REQ-032 A sub-module lfsr32 (seed parameter, load and advance inputs) SHALL be instantiated twice.

Verification
REQ-033 Reset: after RST, A=0, B=0, aluop=ALU_SLL, busy=0, done=0, pass=0, signature=0.
REQ-034 Latency: N_VECTORS=4, start at edge k -> busy=1 after k, done=1 after edge k+80 and not before.
REQ-035 Operand order: op 2, vector 1 -> aluop=ALU_ADD, A=FFFFFFFF, B=1 held for 2 cycles.
REQ-036 Pass path: golden_sig from the bench software model, real ALU connected -> pass=1; same run with golden_sig XOR 1 -> pass=0 and done=1.
REQ-037 Fault detection: bench flips ALUout[0] for op SUB, vector 7 only -> signature differs from golden and pass=0.
REQ-038 Reset mid-run and restart:
  - RST pulse at cycle 30 of a run -> IDLE immediately;
  - start during busy -> ignored;
  - next start -> identical final signature to an undisturbed run.
